// File: rtl/pcm_i2s_pkg.sv
// ============================================================================
// Module   : pcm_i2s_pkg
// Purpose  : Shared types, constants and helpers for the I2S PCM transmitter.
//            SLOT_BITS  - width of one I2S slot (one channel)
//            FRAME_BITS - width of one stereo frame (two slots)
//            tx_state_t - frame-generation state encoding
//            pad_slot() - MSB-aligns a narrower PCM word inside a slot
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcm_i2s_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  // The caller zero-extends a WIDTH-bit word to SLOT_BITS; shifting it up
  // places the word's MSB at the slot MSB and leaves zero LSBs behind it.
  function automatic logic [SLOT_BITS-1:0] pad_slot(
    input logic [SLOT_BITS-1:0] word,
    input int unsigned          width
  );
    pad_slot = word << (SLOT_BITS - width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcm_i2s_bclk_gen.sv
// ============================================================================
// Module   : pcm_i2s_bclk_gen
// Purpose  : Bit-clock divider for the I2S transmitter.
//            Counts MCLK cycles 0..BCLK_DIV-1 while enabled and produces a
//            registered BCLK (low in the first half of the period, high in
//            the second) plus a strobe marking the MCLK edge on which BCLK
//            falls.
// Ports    : mclk_i   - master clock
//            arst_i   - asynchronous active-high reset
//            run_i    - count enable; when low the divider is held at 0
//            bclk_o   - registered bit clock
//            fall_o   - high in the MCLK cycle whose rising edge wraps the
//                       divider to 0 (i.e. the edge that drops BCLK)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcm_i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic mclk_i,
  input  logic arst_i,
  input  logic run_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             w_last;

  // The divider is forced to 0 whenever it is not running, so the terminal
  // count can only be seen while running; no need to qualify with run_i.
  assign w_last = (div_q == DIV_W'(BCLK_DIV - 1));

  always_comb begin
    div_d = '0;
    if (run_i && !w_last) begin
      div_d = div_q + DIV_W'(1);
    end
    // BCLK_DIV is a power of two, so "div >= BCLK_DIV/2" is just the MSB.
    bclk_d = div_d[DIV_W-1];
  end

  always_ff @(posedge mclk_i or posedge arst_i) begin
    if (arst_i) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign fall_o = w_last;

endmodule

`default_nettype wire

// File: rtl/pcm_i2s_tx.sv
// ============================================================================
// Module   : pcm_i2s_tx
// Purpose  : Philips I2S transmitter. Serialises stereo PCM pairs into
//            BCLK/LRCK/DATA, 64 BCLK per frame (two 32-bit slots), with the
//            standard one-BCLK data delay after each LRCK edge. Everything
//            runs on MCLK_I; BCLK_O is a divided, registered signal.
// Ports    : MCLK_I     - master clock (rising edge)
//            ARESET_I   - asynchronous active-high reset
//            ENABLE_I   - start/stop frame generation
//            MUTEN_I    - active-low mute, sampled at frame start
//            PCML_I     - left sample (LENGTH bits, signed)
//            PCMR_I     - right sample (LENGTH bits, signed)
//            VALID_I    - sample pair valid
//            READY_O    - one-entry buffer empty
//            BCLK_O     - bit clock
//            LRCK_O     - word select (0 = left, 1 = right)
//            DATA_O     - serial data, changes with BCLK_O falling
//            UNDERRUN_O - one-MCLK pulse when a frame starts with no pair
// Options  : PCM_I2S_TX_UNDERRUN_HOLD_EN - when defined, an underrun frame
//            repeats the last transmitted pair instead of sending zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcm_i2s_tx
  import pcm_i2s_pkg::*;
#(
  parameter int unsigned LENGTH   = 32,  // 16..32
  parameter int unsigned BCLK_DIV = 4    // even power of two, >= 2
) (
  input  logic              MCLK_I,
  input  logic              ARESET_I,
  input  logic              ENABLE_I,
  input  logic              MUTEN_I,
  input  logic [LENGTH-1:0] PCML_I,
  input  logic [LENGTH-1:0] PCMR_I,
  input  logic              VALID_I,
  output logic              READY_O,
  output logic              BCLK_O,
  output logic              LRCK_O,
  output logic              DATA_O,
  output logic              UNDERRUN_O
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  tx_state_t             state_q, state_d;

  logic [5:0]            bit_q, bit_d;
  logic                  lrck_q, lrck_d;
  logic                  data_q, data_d;
  logic                  und_q, und_d;
  logic                  ready_q;
  logic                  full_q, full_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [LENGTH-1:0]     buf_l_q, buf_r_q;

  logic                  w_cnt_en;
  logic                  w_fall;
  logic                  w_bclk;
  logic                  w_wrap;
  logic                  w_frame_start;
  logic                  w_go_idle;
  logic                  w_accept;
  logic                  w_consume;
  logic [FRAME_BITS-1:0] w_buf_frame;
  logic [FRAME_BITS-1:0] w_underrun_frame;
  logic [FRAME_BITS-1:0] w_load_frame;

  // --------------------------------------------------------------------------
  // Bit-clock divider
  // --------------------------------------------------------------------------
  assign w_cnt_en = (state_q != IDLE);

  pcm_i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .mclk_i (MCLK_I),
    .arst_i (ARESET_I),
    .run_i  (w_cnt_en),
    .bclk_o (w_bclk),
    .fall_o (w_fall)
  );

  // Last fall strobe of the frame: bit counter about to wrap 63 -> 0.
  assign w_wrap = w_fall && (bit_q == 6'd63);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge MCLK_I or posedge ARESET_I) begin
    if (ARESET_I) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ENABLE_I) state_d = RUN;
      end
      RUN: begin
        if (!ENABLE_I) state_d = DRAIN;
      end
      DRAIN: begin
        if (ENABLE_I)    state_d = RUN;
        else if (w_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  // A frame starts on IDLE->RUN entry or on every 63->0 wrap while running.
  // A wrap in DRAIN only starts a new frame if ENABLE_I came back in time;
  // otherwise that wrap ends the stream without loading or flagging underrun.
  always_comb begin
    w_frame_start = 1'b0;
    w_go_idle     = 1'b0;
    unique case (state_q)
      IDLE: begin
        w_frame_start = ENABLE_I;
      end
      RUN: begin
        w_frame_start = w_wrap;
      end
      DRAIN: begin
        w_frame_start = w_wrap && ENABLE_I;
        w_go_idle     = w_wrap && !ENABLE_I;
      end
      default: begin
        w_frame_start = 1'b0;
        w_go_idle     = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sample buffer and frame load value
  // --------------------------------------------------------------------------
  assign w_accept  = VALID_I && ready_q;
  assign w_consume = w_frame_start && full_q;

  assign w_buf_frame = {pad_slot(SLOT_BITS'(buf_l_q), LENGTH),
                        pad_slot(SLOT_BITS'(buf_r_q), LENGTH)};

`ifdef PCM_I2S_TX_UNDERRUN_HOLD_EN
  // Copy of whatever the shift register was last loaded with, replayed when
  // a frame starts with an empty buffer.
  logic [FRAME_BITS-1:0] last_q;

  always_ff @(posedge MCLK_I or posedge ARESET_I) begin
    if (ARESET_I) begin
      last_q <= '0;
    end else if (w_frame_start) begin
      last_q <= w_load_frame;
    end
  end

  assign w_underrun_frame = MUTEN_I ? last_q : '0;
`else
  assign w_underrun_frame = '0;
`endif

  // Mute still consumes a buffered pair; it just transmits silence.
  assign w_load_frame = !full_q   ? w_underrun_frame :
                        !MUTEN_I  ? '0               :
                                    w_buf_frame;

  // A capture in the same cycle as a load leaves the new pair buffered,
  // since the load above reads the old register contents.
  always_comb begin
    full_d = full_q;
    if (w_accept) begin
      full_d = 1'b1;
    end else if (w_consume) begin
      full_d = 1'b0;
    end
  end

  assign und_d = w_frame_start && !full_q;

  // --------------------------------------------------------------------------
  // Serialiser: bit counter, LRCK, DATA, shift register
  // --------------------------------------------------------------------------
  // DATA_O takes shift[63] on the fall strobe that also advances the bit
  // counter, so each bit trails the matching LRCK edge by one BCLK. On the
  // 63->0 wrap the outgoing right LSB is driven and the new frame loaded in
  // the same edge.
  always_comb begin
    bit_d   = bit_q;
    data_d  = data_q;
    shift_d = shift_q;
    if (state_q == IDLE) begin
      bit_d  = '0;
      data_d = 1'b0;
    end else if (w_fall) begin
      bit_d   = bit_q + 6'd1;
      data_d  = shift_q[FRAME_BITS-1];
      shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
    end
    if (w_go_idle) begin
      data_d  = 1'b0;
      shift_d = '0;
    end
    if (w_frame_start) begin
      shift_d = w_load_frame;
    end
    lrck_d = bit_d[5];
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge MCLK_I or posedge ARESET_I) begin
    if (ARESET_I) begin
      bit_q   <= '0;
      lrck_q  <= 1'b0;
      data_q  <= 1'b0;
      und_q   <= 1'b0;
      shift_q <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      bit_q   <= bit_d;
      lrck_q  <= lrck_d;
      data_q  <= data_d;
      und_q   <= und_d;
      shift_q <= shift_d;
      full_q  <= full_d;
      ready_q <= !full_d;
    end
  end

  always_ff @(posedge MCLK_I or posedge ARESET_I) begin
    if (ARESET_I) begin
      buf_l_q <= '0;
      buf_r_q <= '0;
    end else if (w_accept) begin
      buf_l_q <= PCML_I;
      buf_r_q <= PCMR_I;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign READY_O    = ready_q;
  assign BCLK_O     = w_bclk;
  assign LRCK_O     = lrck_q;
  assign DATA_O     = data_q;
  assign UNDERRUN_O = und_q;

endmodule

`default_nettype wire
